shift_sequencer: RTL and testbench

Multi-cycle controller that performs arbitrary-amount SLL/SRL/SRA (shamt 0..31) on the shared ALU. The ALU natively supports only shifts of 1, 2 and 8. The block decomposes shamt into a sequence of 8/2/1 steps, drives the ALU control code and operand each cycle, and feeds the ALU result back into an accumulator. It sits beside the ALU controller in EX, stalls the pipeline while busy, and returns the final result with a one-cycle done pulse.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/shift_step_sel.sv | 48 ++++
 rtl/shift_sequencer.sv | 147 ++++++++++++++
 tb/tb_shift_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the shift sequencer and the ALU controller.
//   - ALU control codes (AND plus the native 1/2/8 shift operations)
//   - Function codes selecting the shift type
//   - Sequencer state encoding and latched shift-type encoding
package alu_pkg;

    localparam logic [5:0] ALU_AND  = 6'h00;
    localparam logic [5:0] ALU_SLL1 = 6'h0A;
    localparam logic [5:0] ALU_SLL2 = 6'h0B;
    localparam logic [5:0] ALU_SLL8 = 6'h0C;
    localparam logic [5:0] ALU_SRL1 = 6'h0D;
    localparam logic [5:0] ALU_SRL2 = 6'h0E;
    localparam logic [5:0] ALU_SRL8 = 6'h0F;
    localparam logic [5:0] ALU_SRA1 = 6'h10;
    localparam logic [5:0] ALU_SRA2 = 6'h11;
    localparam logic [5:0] ALU_SRA8 = 6'h12;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SK_SLL,
        SK_SRL,
        SK_SRA
    } shift_kind_t;

endpackage

// File: rtl/shift_step_sel.sv
// Combinational step selector for the shift sequencer.
// Picks the largest native ALU shift (8, 2 or 1) that does not exceed the
// remaining amount and the matching ALU control code for the latched type.
// Ports:
//   i_rem   remaining shift amount (non-zero while in use)
//   i_kind  latched shift type
//   o_step  amount consumed by this step
//   o_ctrl  ALU control code for this step
module shift_step_sel
    import alu_pkg::*;
#(
    parameter int unsigned SHAMT_W = 5
) (
    input  logic [SHAMT_W-1:0] i_rem,
    input  shift_kind_t        i_kind,
    output logic [SHAMT_W-1:0] o_step,
    output logic [5:0]         o_ctrl
);

    logic [5:0] w_base;
    logic [5:0] w_offset;

    always_comb begin
        w_base = ALU_SLL1;
        case (i_kind)
            SK_SLL:  w_base = ALU_SLL1;
            SK_SRL:  w_base = ALU_SRL1;
            SK_SRA:  w_base = ALU_SRA1;
            default: w_base = ALU_SLL1;
        endcase
    end

    // Codes within each shift type are laid out as 1, 2, 8 consecutively.
    always_comb begin
        o_step   = SHAMT_W'(1);
        w_offset = 6'd0;
        if (i_rem >= SHAMT_W'(8)) begin
            o_step   = SHAMT_W'(8);
            w_offset = 6'd2;
        end else if (i_rem >= SHAMT_W'(2)) begin
            o_step   = SHAMT_W'(2);
            w_offset = 6'd1;
        end
    end

    assign o_ctrl = w_base + w_offset;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA sequencer driving the shared ALU with 8/2/1 steps.
// The ALU result is fed back into the accumulator each SHIFT cycle; the final
// value is returned with a one-cycle done pulse and held until the next start.
// Optional feature macro: SHIFT_SEQ_STATS_EN adds step_count, a saturating
// 16-bit count of issued ALU steps, cleared only by reset.
// Ports:
//   clk, reset     clock; synchronous active-low reset
//   start          request, sampled only in IDLE
//   func, shamt    function code and shift amount, sampled at acceptance
//   operand        value to shift, sampled at acceptance
//   alu_result     combinational ALU output for alu_a/alu_ctrl
//   alu_a          ALU operand (accumulator)
//   alu_ctrl       ALU control code (AND outside SHIFT)
//   busy           pipeline stall, high in SHIFT and DONE
//   done           one-cycle completion pulse
//   result         final shifted value
//   step_count     (SHIFT_SEQ_STATS_EN only) saturating step counter
module shift_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [5:0]         func,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  operand,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [DATA_W-1:0]  alu_a,
    output logic [5:0]         alu_ctrl,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result
`ifdef SHIFT_SEQ_STATS_EN
    ,
    output logic [15:0]        step_count
`endif
);

    state_t             r_state;
    shift_kind_t        r_kind;
    logic [DATA_W-1:0]  r_acc;
    logic [SHAMT_W-1:0] r_rem;
    logic [DATA_W-1:0]  r_result;
    logic               r_done;
    logic               r_busy;

    logic [SHAMT_W-1:0] w_step;
    logic [5:0]         w_ctrl;
    logic               w_func_ok;
    shift_kind_t        w_kind;

    shift_step_sel #(
        .SHAMT_W (SHAMT_W)
    ) u_step_sel (
        .i_rem  (r_rem),
        .i_kind (r_kind),
        .o_step (w_step),
        .o_ctrl (w_ctrl)
    );

    always_comb begin
        w_func_ok = 1'b1;
        w_kind    = SK_SLL;
        case (func)
            FN_SLL:  w_kind = SK_SLL;
            FN_SRL:  w_kind = SK_SRL;
            FN_SRA:  w_kind = SK_SRA;
            default: w_func_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_kind   <= SK_SLL;
            r_acc    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_acc  <= operand;
                        r_busy <= 1'b1;
                        if (w_func_ok && (shamt != '0)) begin
                            r_rem   <= shamt;
                            r_kind  <= w_kind;
                            r_state <= SHIFT;
                        end else begin
                            // Pass-through: no ALU operations issued.
                            r_result <= operand;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    r_acc <= alu_result;
                    r_rem <= r_rem - w_step;
                    // Result is registered on DONE entry so it is valid with done.
                    if (r_rem == w_step) begin
                        r_result <= alu_result;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_a    = r_acc;
    assign alu_ctrl = (r_state == SHIFT) ? w_ctrl : ALU_AND;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;

`ifdef SHIFT_SEQ_STATS_EN
    logic [15:0] r_step_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_step_count <= '0;
        end else if ((r_state == SHIFT) && (r_step_count != '1)) begin
            r_step_count <= r_step_count + 16'd1;
        end
    end

    assign step_count = r_step_count;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized
// operations checked against an arithmetic reference of the shift semantics.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [31:0] operand;
    logic [31:0] alu_result;
    logic [31:0] alu_a;
    logic [5:0]  alu_ctrl;
    logic        busy;
    logic        done;
    logic [31:0] result;
`ifdef SHIFT_SEQ_STATS_EN
    logic [15:0] step_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned total_steps = 0;

    always #5 clk = ~clk;

    shift_sequencer #(
        .DATA_W  (32),
        .SHAMT_W (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .func       (func),
        .shamt      (shamt),
        .operand    (operand),
        .alu_result (alu_result),
        .alu_a      (alu_a),
        .alu_ctrl   (alu_ctrl),
        .busy       (busy),
        .done       (done),
        .result     (result)
`ifdef SHIFT_SEQ_STATS_EN
        ,
        .step_count (step_count)
`endif
    );

    // Shared ALU: only the native shift codes are meaningful here; anything
    // else yields a poison value the sequencer must never consume.
    always_comb begin
        case (alu_ctrl)
            6'h0A:   alu_result = alu_a << 1;
            6'h0B:   alu_result = alu_a << 2;
            6'h0C:   alu_result = alu_a << 8;
            6'h0D:   alu_result = alu_a >> 1;
            6'h0E:   alu_result = alu_a >> 2;
            6'h0F:   alu_result = alu_a >> 8;
            6'h10:   alu_result = 32'($signed(alu_a) >>> 1);
            6'h11:   alu_result = 32'($signed(alu_a) >>> 2);
            6'h12:   alu_result = 32'($signed(alu_a) >>> 8);
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit fn_valid(input logic [5:0] f);
        return (f == 6'h00) || (f == 6'h02) || (f == 6'h03);
    endfunction

    function automatic logic [31:0] ref_shift(input logic [5:0] f, input int unsigned sh,
                                              input logic [31:0] op);
        case (f)
            6'h00:   return op << sh;
            6'h02:   return op >> sh;
            6'h03:   return 32'($signed(op) >>> sh);
            default: return op;
        endcase
    endfunction

    task automatic run_op(input logic [5:0] f, input int unsigned sh,
                          input logic [31:0] op, input bit poke);
        logic [31:0] exp;
        logic [5:0]  seq[$];
        logic [5:0]  base;
        exp = ref_shift(f, sh, op);
        seq = {};
        if (fn_valid(f) && sh != 0) begin
            base = (f == 6'h00) ? 6'h0A : (f == 6'h02) ? 6'h0D : 6'h10;
            repeat (sh / 8)       seq.push_back(base + 6'd2);
            repeat ((sh % 8) / 2) seq.push_back(base + 6'd1);
            repeat (sh % 2)       seq.push_back(base);
        end
        total_steps += seq.size();

        @(negedge clk);
        func = f; shamt = 5'(sh); operand = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < seq.size(); k++) begin
            check("shift_busy", 32'(busy), 32'd1);
            check("shift_done", 32'(done), 32'd0);
            check($sformatf("ctrl[%0d]", k), 32'(alu_ctrl), 32'(seq[k]));
            // Later input changes and stray starts must have no effect.
            func = 6'($urandom); shamt = 5'($urandom); operand = $urandom;
            if (poke) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'b0;
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_result", result, exp);
        check("done_ctrl", 32'(alu_ctrl), 32'h00);
        check("done_alu_a", alu_a, exp);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_result", result, exp);
        check("idle_ctrl", 32'(alu_ctrl), 32'h00);
    endtask

    task automatic check_reset_state();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ctrl", 32'(alu_ctrl), 32'h00);
        check("rst_alu_a", alu_a, 32'd0);
    endtask

    initial begin
        logic [5:0] f;
        reset = 1'b0; start = 1'b0; func = '0; shamt = '0; operand = '0;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b1;
        total_steps = 0;

        run_op(6'h00, 31, 32'h0000_0001, 1'b0);
        run_op(6'h03, 13, 32'h8000_0000, 1'b0);
        run_op(6'h02, 4,  32'hF000_0000, 1'b1);
        run_op(6'h02, 0,  32'h1234_5678, 1'b0);
        run_op(6'h05, 7,  32'hCAFE_F00D, 1'b1);

        // Reset during the third SHIFT cycle aborts with no done pulse.
        @(negedge clk);
        func = 6'h00; shamt = 5'd31; operand = 32'h0000_0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_ctrl", 32'(alu_ctrl), 32'h0C);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state();
        reset = 1'b1;
        total_steps = 0;
        run_op(6'h00, 1, 32'h0000_0003, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       f = 6'h00;
                1:       f = 6'h02;
                2:       f = 6'h03;
                3:       f = 6'($urandom);
                default: f = 6'h03;
            endcase
            run_op(f, $urandom_range(0, 31), $urandom, 1'($urandom_range(0, 1)));
        end

`ifdef SHIFT_SEQ_STATS_EN
        check("step_count", 32'(step_count),
              (total_steps > 32'hFFFF) ? 32'hFFFF : total_steps);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
